// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN IP output stage.
// Holds the feeder FSM state encoding and the default datapath sizes
// used by paced_stream_feeder, its FIFO and its stream interface.
package cnn_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PRESENT = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/paced_stream_feeder_if.sv
// Valid/ready word stream used on both sides of paced_stream_feeder.
//   data  : word carried by the stream
//   valid : producer has a word on data
//   ready : consumer takes the word this cycle when valid is also high
// master drives data/valid, slave drives ready.
interface paced_stream_feeder_if
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/feeder_fifo.sv
// Synchronous FIFO for paced_stream_feeder.
//   clock_in, reset_n : clock, async active-low reset
//   wr_en, wr_data    : push a word (caller guarantees !full)
//   pop               : drop the head word (caller guarantees !empty)
//   head              : current head word, valid while !empty
//   level             : occupancy 0..DEPTH
//   full, empty       : derived from level
// No fall-through: a word written into an empty FIFO shows up on head
// only after the write edge.
module feeder_fifo
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [ADDR_W:0]       level,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // Storage carries no reset; a slot is only read after it was written.
    always_ff @(posedge clock_in) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/paced_stream_feeder.sv
// Rate-paced output stage behind the CNN clock divider.
// Buffers upstream words and releases one word per rising edge of the
// divider pulse onto a valid/ready stream.
//   clock_in, reset_n : clock, async active-low reset
//   tick_in           : divider pulse, already synchronous to clock_in
//   enable            : pacing enable
//   clear             : synchronous clear of the sticky flags
//   s                 : upstream stream (ready = FIFO not full)
//   m                 : downstream stream, data/valid are registers
//   level             : FIFO occupancy 0..DEPTH
//   underrun          : sticky, tick seen in ARMED with nothing buffered
//   missed_tick       : sticky, tick seen while a word was still pending
module paced_stream_feeder
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                   clock_in,
    input  logic                   reset_n,
    input  logic                   tick_in,
    input  logic                   enable,
    input  logic                   clear,
    paced_stream_feeder_if.slave   s,
    paced_stream_feeder_if.master  m,
    output logic [ADDR_W:0]        level,
    output logic                   underrun,
    output logic                   missed_tick
);

    feeder_state_t         state, state_nx;
    logic                  tick_d;
    logic                  tick_rise;
    logic                  full, empty;
    logic                  wr_en, pop, handshake;
    logic                  set_underrun, set_missed;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;

    // tick_d resets high so a pulse already high at reset release is not
    // mistaken for a fresh edge.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) tick_d <= 1'b1;
        else          tick_d <= tick_in;
    end
    assign tick_rise = tick_in & ~tick_d;

    assign s.ready   = ~full;
    assign wr_en     = s.valid & ~full;
    assign handshake = out_valid & m.ready;

    feeder_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (s.data),
        .pop      (pop),
        .head     (head),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        pop          = 1'b0;
        set_underrun = 1'b0;
        set_missed   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nx = ARMED;
            end
            ARMED: begin
                // Dropping enable wins over a same-cycle tick.
                if (!enable) begin
                    state_nx = IDLE;
                end else if (tick_rise) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = PRESENT;
                    end else begin
                        set_underrun = 1'b1;
                    end
                end
            end
            PRESENT: begin
                // A pending word is always completed, even with enable low;
                // a tick on the handshake cycle is simply consumed.
                if (handshake)
                    state_nx = enable ? ARMED : IDLE;
                else if (tick_rise)
                    set_missed = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= head;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    assign m.valid = out_valid;
    assign m.data  = out_data;

    // A setting event beats a same-cycle clear.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            underrun    <= 1'b0;
            missed_tick <= 1'b0;
        end else begin
            if (set_underrun) underrun <= 1'b1;
            else if (clear)   underrun <= 1'b0;
            if (set_missed)   missed_tick <= 1'b1;
            else if (clear)   missed_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_paced_stream_feeder.sv
// Self-checking bench for paced_stream_feeder: a directed vector table,
// hand-written corner sequences, then randomized traffic, all compared
// every cycle against a queue-based reference model.
module tb_paced_stream_feeder;
    import cnn_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam int M_IDLE    = 0;
    localparam int M_ARMED   = 1;
    localparam int M_PRESENT = 2;

    logic          clock_in = 1'b0;
    logic          reset_n  = 1'b0;
    logic          tick_in  = 1'b1;
    logic          enable   = 1'b0;
    logic          clear    = 1'b0;
    logic [AW:0]   level;
    logic          underrun;
    logic          missed_tick;

    paced_stream_feeder_if #(.DATA_WIDTH(DW)) s_bus ();
    paced_stream_feeder_if #(.DATA_WIDTH(DW)) m_bus ();

    always #5 clock_in = ~clock_in;

    paced_stream_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .tick_in     (tick_in),
        .enable      (enable),
        .clear       (clear),
        .s           (s_bus.slave),
        .m           (m_bus.master),
        .level       (level),
        .underrun    (underrun),
        .missed_tick (missed_tick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: buffered words in a queue, one presented word.
    logic [DW-1:0] q[$];
    bit            mdl_tick_d;
    int            mdl_mode;
    bit            mdl_mv;
    logic [DW-1:0] mdl_md;
    bit            mdl_und;
    bit            mdl_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mdl_tick_d = 1'b1;
        mdl_mode   = M_IDLE;
        mdl_mv     = 1'b0;
        mdl_md     = '0;
        mdl_und    = 1'b0;
        mdl_mis    = 1'b0;
    endtask

    // Applies one clock of the rules to the model using the current inputs.
    task automatic model_step();
        bit            rise   = tick_in && !mdl_tick_d;
        int            sz     = q.size();
        bit            can_wr = s_bus.valid && (sz < DEPTH);
        logic [DW-1:0] wd     = s_bus.data;
        bit            su     = 1'b0;
        bit            sm     = 1'b0;
        case (mdl_mode)
            M_IDLE: if (enable) mdl_mode = M_ARMED;
            M_ARMED: begin
                if (!enable) mdl_mode = M_IDLE;
                else if (rise) begin
                    if (sz > 0) begin
                        mdl_md   = q.pop_front();
                        mdl_mv   = 1'b1;
                        mdl_mode = M_PRESENT;
                    end else su = 1'b1;
                end
            end
            default: begin
                if (m_bus.ready) begin
                    mdl_mv   = 1'b0;
                    mdl_mode = enable ? M_ARMED : M_IDLE;
                end else if (rise) sm = 1'b1;
            end
        endcase
        if (can_wr) q.push_back(wd);
        mdl_und    = su ? 1'b1 : (clear ? 1'b0 : mdl_und);
        mdl_mis    = sm ? 1'b1 : (clear ? 1'b0 : mdl_mis);
        mdl_tick_d = tick_in;
    endtask

    task automatic check_model();
        chk("mdl_m_valid", m_bus.valid, mdl_mv);
        chk("mdl_m_data", m_bus.data, mdl_md);
        chk("mdl_level", level, q.size());
        chk("mdl_s_ready", s_bus.ready, (q.size() < DEPTH));
        chk("mdl_underrun", underrun, mdl_und);
        chk("mdl_missed_tick", missed_tick, mdl_mis);
    endtask

    // One clock: inputs are already set; check 1 time unit after the edge.
    task automatic cycle();
        @(posedge clock_in);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        bit            tick;
        bit            en;
        bit            clr;
        bit            sv;
        logic [DW-1:0] sd;
        bit            mr;
        bit            exp_mv;
        logic [DW-1:0] exp_md;
        int            exp_lvl;
        bit            exp_und;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // tick_in held high through reset: that level must not count as an edge.
        tbl[0]  = '{1, 0, 0, 1, 8'h11, 1,  0, 8'h00, 1, 0};
        tbl[1]  = '{1, 0, 0, 1, 8'h22, 1,  0, 8'h00, 2, 0};
        tbl[2]  = '{1, 0, 0, 1, 8'h33, 1,  0, 8'h00, 3, 0};
        tbl[3]  = '{1, 1, 0, 0, 8'h00, 1,  0, 8'h00, 3, 0};
        tbl[4]  = '{1, 1, 0, 0, 8'h00, 1,  0, 8'h00, 3, 0};
        tbl[5]  = '{0, 1, 0, 0, 8'h00, 1,  0, 8'h00, 3, 0};
        tbl[6]  = '{1, 1, 0, 0, 8'h00, 1,  1, 8'h11, 2, 0};
        tbl[7]  = '{0, 1, 0, 0, 8'h00, 1,  0, 8'h11, 2, 0};
        tbl[8]  = '{1, 1, 0, 0, 8'h00, 1,  1, 8'h22, 1, 0};
        tbl[9]  = '{0, 1, 0, 0, 8'h00, 1,  0, 8'h22, 1, 0};
        tbl[10] = '{1, 1, 0, 0, 8'h00, 1,  1, 8'h33, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 8'h00, 1,  0, 8'h33, 0, 0};
        tbl[12] = '{1, 1, 0, 0, 8'h00, 1,  0, 8'h33, 0, 1};
        tbl[13] = '{0, 1, 1, 0, 8'h00, 1,  0, 8'h33, 0, 0};
        tbl[14] = '{0, 1, 0, 0, 8'h00, 1,  0, 8'h33, 0, 0};

        s_bus.valid = 1'b0;
        s_bus.data  = '0;
        m_bus.ready = 1'b1;
        model_reset();

        // Reset state
        #22;
        chk("rst_level", level, 0);
        chk("rst_s_ready", s_bus.ready, 1);
        chk("rst_m_valid", m_bus.valid, 0);
        chk("rst_m_data", m_bus.data, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_missed_tick", missed_tick, 0);
        @(posedge clock_in);
        #1 reset_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            tick_in     = tbl[i].tick;
            enable      = tbl[i].en;
            clear       = tbl[i].clr;
            s_bus.valid = tbl[i].sv;
            s_bus.data  = tbl[i].sd;
            m_bus.ready = tbl[i].mr;
            cycle();
            chk("tv_m_valid", m_bus.valid, tbl[i].exp_mv);
            chk("tv_m_data", m_bus.data, tbl[i].exp_md);
            chk("tv_level", level, tbl[i].exp_lvl);
            chk("tv_underrun", underrun, tbl[i].exp_und);
            chk("tv_missed_tick", missed_tick, 0);
            if (i == 3) chk("tv_state_armed", int'(dut.state), int'(ARMED));
        end
        clear = 1'b0;

        // Word held across two ticks with m_ready low
        tick_in = 1'b0; m_bus.ready = 1'b0;
        s_bus.valid = 1'b1; s_bus.data = 8'hA5; cycle();
        s_bus.valid = 1'b0; cycle();
        tick_in = 1'b1; cycle();
        chk("hold_first_valid", m_bus.valid, 1);
        chk("hold_first_data", m_bus.data, 8'hA5);
        tick_in = 1'b0; cycle();
        tick_in = 1'b1; cycle();
        chk("hold_missed", missed_tick, 1);
        chk("hold_valid", m_bus.valid, 1);
        chk("hold_data", m_bus.data, 8'hA5);
        tick_in = 1'b0; cycle();
        m_bus.ready = 1'b1; cycle();
        chk("hold_xfer_done", m_bus.valid, 0);
        chk("hold_state_armed", int'(dut.state), int'(ARMED));
        clear = 1'b1; cycle();
        clear = 1'b0;
        chk("hold_missed_clr", missed_tick, 0);

        // Tick coinciding with the handshake is not a miss
        m_bus.ready = 1'b0;
        s_bus.valid = 1'b1; s_bus.data = 8'h5A; cycle();
        s_bus.valid = 1'b0; tick_in = 1'b1; cycle();
        chk("coin_valid", m_bus.valid, 1);
        tick_in = 1'b0; cycle();
        tick_in = 1'b1; m_bus.ready = 1'b1; cycle();
        chk("coin_no_miss", missed_tick, 0);
        chk("coin_xfer", m_bus.valid, 0);
        tick_in = 1'b0; cycle();
        chk("coin_level", level, 0);
        chk("coin_no_underrun", underrun, 0);

        // Fill to DEPTH with pacing off; the 17th word is refused
        enable = 1'b0; cycle();
        s_bus.valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            s_bus.data = 8'h80 + 8'(i);
            cycle();
        end
        s_bus.valid = 1'b0;
        chk("full_level", level, DEPTH);
        chk("full_s_ready", s_bus.ready, 0);
        enable = 1'b1; cycle();
        tick_in = 1'b1; cycle();
        chk("full_pop_data", m_bus.data, 8'h80);
        chk("full_pop_level", level, DEPTH - 1);
        chk("full_pop_s_ready", s_bus.ready, 1);
        tick_in = 1'b0; cycle();

        // Drop enable while a word is presented
        m_bus.ready = 1'b0;
        tick_in = 1'b1; cycle();
        tick_in = 1'b0; enable = 1'b0; cycle(); cycle();
        chk("dis_valid_held", m_bus.valid, 1);
        chk("dis_data_held", m_bus.data, 8'h81);
        m_bus.ready = 1'b1; cycle();
        chk("dis_xfer", m_bus.valid, 0);
        chk("dis_state_idle", int'(dut.state), int'(IDLE));
        for (int k = 0; k < 3; k++) begin
            tick_in = 1'b1; cycle();
            tick_in = 1'b0; cycle();
        end
        chk("dis_level", level, DEPTH - 2);
        chk("dis_no_underrun", underrun, 0);
        chk("dis_no_missed", missed_tick, 0);
        chk("dis_no_valid", m_bus.valid, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick_in     = ($urandom_range(0, 5) == 0);
            enable      = ($urandom_range(0, 19) != 0);
            clear       = ($urandom_range(0, 29) == 0);
            s_bus.valid = ($urandom_range(0, 1) == 0);
            s_bus.data  = 8'($urandom);
            m_bus.ready = ($urandom_range(0, 9) < 6);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
